// File: rtl/adder_tree_pipe.sv
// ============================================================================
//  Module   : adder_tree_pipe
//  Purpose  : Masked, fully pipelined signed adder tree with a sum and a floor-mean output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module adder_tree_pipe #(
    parameter  int N_CH  = 16,
    parameter  int IN_W  = 19,
    localparam int LG    = $clog2(N_CH),
    localparam int OUT_W = IN_W + LG
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH*IN_W-1:0]   in_data,
    input  logic [N_CH-1:0]        ch_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_sum,
    output logic [IN_W-1:0]        out_mean
);

    logic          w_adv;
    logic [LG-1:0] r_vld;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_adv     = !out_valid || out_ready;
    // Reset forces ready high even if a result was still being held.
    assign in_ready  = w_adv || rst;
    assign out_valid = r_vld[LG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (w_adv) begin
            for (int j = LG - 1; j > 0; j--) begin
                r_vld[j] <= r_vld[j-1];
            end
            r_vld[0] <= in_valid;
        end
    end

    for (genvar j = 1; j <= LG; j++) begin : g_lvl
        localparam int c_w = IN_W + j;
        localparam int c_n = N_CH >> j;

        for (genvar k = 0; k < c_n; k++) begin : g_node
            logic [c_w-2:0] w_a;
            logic [c_w-2:0] w_b;
            logic [c_w-1:0] r_sum;

            if (j == 1) begin : g_leaf
                assign w_a = ch_mask[2*k]   ? in_data[(2*k)*IN_W   +: IN_W] : '0;
                assign w_b = ch_mask[2*k+1] ? in_data[(2*k+1)*IN_W +: IN_W] : '0;
            end else begin : g_inner
                assign w_a = g_lvl[j-1].g_node[2*k].r_sum;
                assign w_b = g_lvl[j-1].g_node[2*k+1].r_sum;
            end

            // One guard bit per level keeps every partial sum exact.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_sum <= {w_a[c_w-2], w_a} + {w_b[c_w-2], w_b};
                end
            end
        end
    end

    assign out_sum  = g_lvl[LG].g_node[0].r_sum;
    assign out_mean = out_sum[OUT_W-1:LG];

endmodule

`default_nettype wire
